rename_unit: RTL and testbench

- Rename/dispatch stage directly upstream of the reservation station.
- Maps architectural sources and destinations to PRF tags using a RAT, a free-list FIFO and a per-tag ready table.
- Allocates a destination PRF tag and a ROB tag, then drives the RS write port (valid_issue, tag_PRF, tag_ROB, valid_Ra/tag_Ra, valid_Rb/tag_Rb) in the same cycle.
- Snoops the add/mul result broadcasts and accepts tag releases from commit.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/free_list_fifo.sv | 73 +++++++
 rtl/rename_unit.sv | 152 +++++++++++++++
 tb/tb_rename_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared rename/issue types and reset-mapping constants.
// Used by the rename unit and, downstream, by the RS and ROB.
package cpu_pkg;

    localparam int ARCH_REGS = 8;
    localparam int PRF_NUM   = 16;
    localparam int ROB_NUM   = 16;

    localparam int ARCH_W = $clog2(ARCH_REGS);
    localparam int TAG_W  = $clog2(PRF_NUM);
    localparam int ROB_W  = $clog2(ROB_NUM);

    typedef logic [ARCH_W-1:0] arch_reg_t;
    typedef logic [TAG_W-1:0]  prf_tag_t;
    typedef logic [ROB_W-1:0]  rob_tag_t;

    // After reset, architectural register i lives in physical register i.
    // The remaining physical registers start out free, lowest tag first.
    localparam int FREE_INIT_CNT  = PRF_NUM - ARCH_REGS;
    localparam int FREE_INIT_BASE = ARCH_REGS;

    function automatic prf_tag_t reset_map(input arch_reg_t a);
        return prf_tag_t'(a);
    endfunction

endpackage

// File: rtl/free_list_fifo.sv
// Circular FIFO of free physical register tags.
// DEPTH must be a power of two so the pointers wrap naturally.
// A tag pushed this cycle only becomes visible at head on a later cycle.
module free_list_fifo #(
    parameter int DEPTH     = 16,
    parameter int W         = 4,
    parameter int INIT_CNT  = 8,
    parameter int INIT_BASE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stop,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign head_data = mem_q[head_q];
    assign count     = cnt_q;
    assign empty     = (cnt_q == '0);

    // Next-state: write at tail, advance head, track occupancy.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        do_pop  = pop & (cnt_q != '0);
        do_push = push & (cnt_q != FULL_CNT);
        if (do_push) begin
            mem_d[tail_q] = push_data;
            tail_d        = tail_q + 1'b1;
        end
        if (do_pop) begin
            head_d = head_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State register; reset and stop both reload the initial free tags.
    always_ff @(posedge clk) begin
        if (!rst || stop) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= W'(INIT_BASE + i);
            end
            head_q <= '0;
            tail_q <= PW'(INIT_CNT);
            cnt_q  <= (PW+1)'(INIT_CNT);
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rename_unit.sv
// Rename/dispatch stage feeding the reservation station.
// RAT + per-tag ready table + free list; RS outputs are combinational so
// the RS captures the instruction on the same edge that rename updates.
// Optional: RENAME_ZERO_REG_EN makes r0 a hardwired, always-ready tag 0.
module rename_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stop,
    input  logic              valid_in,
    input  logic              valid_opcode_in,
    input  logic              use_Rd,
    input  logic [ARCH_W-1:0] Rd,
    input  logic [ARCH_W-1:0] Ra,
    input  logic [ARCH_W-1:0] Rb,
    output logic              ready_out,
    input  logic              rs_full,
    input  logic              rob_full,
    output logic              valid_issue,
    output logic              valid_opcode,
    output logic [TAG_W-1:0]  tag_PRF,
    output logic [ROB_W-1:0]  tag_ROB,
    output logic [TAG_W-1:0]  tag_old_PRF,
    output logic              valid_Ra,
    output logic              valid_Rb,
    output logic [TAG_W-1:0]  tag_Ra,
    output logic [TAG_W-1:0]  tag_Rb,
    input  logic              valid_Result_add,
    input  logic              valid_Result_mul,
    input  logic [TAG_W-1:0]  tag_PRF_add,
    input  logic [TAG_W-1:0]  tag_PRF_mul,
    input  logic              valid_commit,
    input  logic [TAG_W-1:0]  tag_free
);
    prf_tag_t             rat_q [ARCH_REGS];
    prf_tag_t             rat_d [ARCH_REGS];
    logic [PRF_NUM-1:0]   ready_q, ready_d;
    rob_tag_t             rob_ptr_q, rob_ptr_d;

    logic                 need_rd, fire, alloc, fl_push, fl_empty;
    prf_tag_t             fl_head;
    logic [TAG_W:0]       free_cnt;
    prf_tag_t             src_a_tag, src_b_tag;
    logic                 src_a_rdy, src_b_rdy;

`ifdef RENAME_ZERO_REG_EN
    // Writes to r0 are discarded, and tag 0 is reserved for r0.
    assign need_rd = use_Rd & (Rd != '0);
    assign fl_push = valid_commit & (tag_free != '0);
`else
    assign need_rd = use_Rd;
    assign fl_push = valid_commit;
`endif

    assign ready_out = !rs_full && !rob_full && ((free_cnt != '0) || !need_rd);
    assign fire      = valid_in & ready_out;
    assign alloc     = fire & need_rd & !fl_empty;

    free_list_fifo #(
        .DEPTH     (PRF_NUM),
        .W         (TAG_W),
        .INIT_CNT  (FREE_INIT_CNT),
        .INIT_BASE (FREE_INIT_BASE)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .stop      (stop),
        .push      (fl_push),
        .push_data (tag_free),
        .pop       (alloc),
        .head_data (fl_head),
        .count     (free_cnt),
        .empty     (fl_empty)
    );

    // Source lookup against the pre-update RAT, with result-bus bypass.
    always_comb begin
        src_a_tag = rat_q[Ra];
        src_b_tag = rat_q[Rb];
        src_a_rdy = ready_q[src_a_tag]
                  | (valid_Result_add & (tag_PRF_add == src_a_tag))
                  | (valid_Result_mul & (tag_PRF_mul == src_a_tag));
        src_b_rdy = ready_q[src_b_tag]
                  | (valid_Result_add & (tag_PRF_add == src_b_tag))
                  | (valid_Result_mul & (tag_PRF_mul == src_b_tag));
`ifdef RENAME_ZERO_REG_EN
        if (Ra == '0) begin
            src_a_tag = '0;
            src_a_rdy = 1'b1;
        end
        if (Rb == '0) begin
            src_b_tag = '0;
            src_b_rdy = 1'b1;
        end
`endif
    end

    // RS write port: everything is zero unless an instruction issues.
    always_comb begin
        valid_issue  = fire;
        valid_opcode = 1'b0;
        tag_PRF      = '0;
        tag_old_PRF  = '0;
        tag_ROB      = '0;
        tag_Ra       = '0;
        tag_Rb       = '0;
        valid_Ra     = 1'b0;
        valid_Rb     = 1'b0;
        if (fire) begin
            valid_opcode = valid_opcode_in;
            tag_ROB      = rob_ptr_q;
            tag_Ra       = src_a_tag;
            tag_Rb       = src_b_tag;
            valid_Ra     = src_a_rdy;
            valid_Rb     = src_b_rdy;
            if (need_rd) begin
                tag_PRF     = fl_head;
                tag_old_PRF = rat_q[Rd];
            end
        end
    end

    // Next-state for RAT, ready table and ROB pointer.
    always_comb begin
        rat_d     = rat_q;
        ready_d   = ready_q;
        rob_ptr_d = rob_ptr_q + ROB_W'(fire);
        if (valid_Result_add) ready_d[tag_PRF_add] = 1'b1;
        if (valid_Result_mul) ready_d[tag_PRF_mul] = 1'b1;
        if (alloc) begin
            rat_d[Rd]        = fl_head;
            ready_d[fl_head] = 1'b0;
        end
    end

    // State register; stop is a synchronous flush identical to reset.
    always_ff @(posedge clk) begin
        if (!rst || stop) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= reset_map(arch_reg_t'(i));
            end
            ready_q   <= '1;
            rob_ptr_q <= '0;
        end else begin
            rat_q     <= rat_d;
            ready_q   <= ready_d;
            rob_ptr_q <= rob_ptr_d;
        end
    end

endmodule

// File: tb/tb_rename_unit.sv
// Directed self-checking bench for rename_unit.
module tb_rename_unit;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst, stop;
    logic              valid_in, valid_opcode_in, use_Rd;
    logic [ARCH_W-1:0] Rd, Ra, Rb;
    logic              ready_out, rs_full, rob_full;
    logic              valid_issue, valid_opcode;
    logic [TAG_W-1:0]  tag_PRF, tag_old_PRF, tag_Ra, tag_Rb;
    logic [ROB_W-1:0]  tag_ROB;
    logic              valid_Ra, valid_Rb;
    logic              valid_Result_add, valid_Result_mul;
    logic [TAG_W-1:0]  tag_PRF_add, tag_PRF_mul;
    logic              valid_commit;
    logic [TAG_W-1:0]  tag_free;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock
    always #5 clk = ~clk;

    rename_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stop             (stop),
        .valid_in         (valid_in),
        .valid_opcode_in  (valid_opcode_in),
        .use_Rd           (use_Rd),
        .Rd               (Rd),
        .Ra               (Ra),
        .Rb               (Rb),
        .ready_out        (ready_out),
        .rs_full          (rs_full),
        .rob_full         (rob_full),
        .valid_issue      (valid_issue),
        .valid_opcode     (valid_opcode),
        .tag_PRF          (tag_PRF),
        .tag_ROB          (tag_ROB),
        .tag_old_PRF      (tag_old_PRF),
        .valid_Ra         (valid_Ra),
        .valid_Rb         (valid_Rb),
        .tag_Ra           (tag_Ra),
        .tag_Rb           (tag_Rb),
        .valid_Result_add (valid_Result_add),
        .valid_Result_mul (valid_Result_mul),
        .tag_PRF_add      (tag_PRF_add),
        .tag_PRF_mul      (tag_PRF_mul),
        .valid_commit     (valid_commit),
        .tag_free         (tag_free)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction; side-band inputs return to idle.
    task automatic drive(input logic v, input logic u, input logic [ARCH_W-1:0] rd,
                         input logic [ARCH_W-1:0] ra, input logic [ARCH_W-1:0] rb);
        valid_in         = v;
        valid_opcode_in  = v;
        use_Rd           = u;
        Rd               = rd;
        Ra               = ra;
        Rb               = rb;
        rs_full          = 1'b0;
        rob_full         = 1'b0;
        valid_Result_add = 1'b0;
        valid_Result_mul = 1'b0;
        tag_PRF_add      = '0;
        tag_PRF_mul      = '0;
        valid_commit     = 1'b0;
        tag_free         = '0;
        stop             = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [TAG_W-1:0] exp_tag, exp_old, last_tag, old_prev;

    initial begin
        // Reset
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        settle();
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        chk("rst_valid_issue", 32'(valid_issue), 32'd0);
        chk("rst_tag_prf", 32'(tag_PRF), 32'd0);
        chk("rst_tag_ra", 32'(tag_Ra), 32'd0);

        // First rename: Rd=1, Ra=1, Rb=2
        drive(1'b1, 1'b1, 3'd1, 3'd1, 3'd2);
        settle();
        chk("t1_valid_issue", 32'(valid_issue), 32'd1);
        chk("t1_valid_opcode", 32'(valid_opcode), 32'd1);
        chk("t1_tag_prf", 32'(tag_PRF), 32'd8);
        chk("t1_tag_old", 32'(tag_old_PRF), 32'd1);
        chk("t1_tag_ra", 32'(tag_Ra), 32'd1);
        chk("t1_tag_rb", 32'(tag_Rb), 32'd2);
        chk("t1_valid_ra", 32'(valid_Ra), 32'd1);
        chk("t1_valid_rb", 32'(valid_Rb), 32'd1);
        chk("t1_tag_rob", 32'(tag_ROB), 32'd0);
        tick();

        // RAT[1]=8 and tag 8 not ready; no-destination instruction
        drive(1'b1, 1'b0, 3'd5, 3'd1, 3'd1);
        settle();
        chk("t1b_tag_ra", 32'(tag_Ra), 32'd8);
        chk("t1b_valid_ra", 32'(valid_Ra), 32'd0);
        chk("t1b_tag_prf", 32'(tag_PRF), 32'd0);
        chk("t1b_tag_old", 32'(tag_old_PRF), 32'd0);
        chk("t1b_tag_rob", 32'(tag_ROB), 32'd1);
        tick();

        // Rename Rd=3 -> tag 9
        drive(1'b1, 1'b1, 3'd3, 3'd0, 3'd0);
        settle();
        chk("t2_tag_prf", 32'(tag_PRF), 32'd9);
        chk("t2_tag_old", 32'(tag_old_PRF), 32'd3);
        chk("t2_tag_rob", 32'(tag_ROB), 32'd2);
        tick();

        // Same-cycle bypass: add broadcasts 9, mul broadcasts 8
        drive(1'b1, 1'b0, 3'd0, 3'd3, 3'd1);
        valid_Result_add = 1'b1;
        tag_PRF_add      = 4'd9;
        valid_Result_mul = 1'b1;
        tag_PRF_mul      = 4'd8;
        settle();
        chk("t2_bypass_tag_ra", 32'(tag_Ra), 32'd9);
        chk("t2_bypass_valid_ra", 32'(valid_Ra), 32'd1);
        chk("t2_bypass_tag_rb", 32'(tag_Rb), 32'd8);
        chk("t2_bypass_valid_rb", 32'(valid_Rb), 32'd1);
        tick();

        // Broadcast has now set the ready bits
        drive(1'b1, 1'b0, 3'd0, 3'd3, 3'd1);
        settle();
        chk("t2_after_valid_ra", 32'(valid_Ra), 32'd1);
        chk("t2_after_valid_rb", 32'(valid_Rb), 32'd1);
        chk("t2_after_tag_rob", 32'(tag_ROB), 32'd4);
        tick();

        // Flush
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        stop = 1'b1;
        tick();

        // Eight back-to-back renames drain the free list
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'((i % 7) + 1), 3'd0, 3'd0);
            settle();
            chk("t3_tag_prf", 32'(tag_PRF), 32'(8 + i));
            chk("t3_tag_rob", 32'(tag_ROB), 32'(i));
            if (i == 0) chk("t3_first_old", 32'(tag_old_PRF), 32'd1);
            if (i == 7) chk("t3_last_old", 32'(tag_old_PRF), 32'd8);
            tick();
        end

        // Empty: stall while tag 4 is released (no bypass)
        drive(1'b1, 1'b1, 3'd2, 3'd0, 3'd0);
        valid_commit = 1'b1;
        tag_free     = 4'd4;
        settle();
        chk("t3_empty_ready_out", 32'(ready_out), 32'd0);
        chk("t3_empty_valid_issue", 32'(valid_issue), 32'd0);
        chk("t3_empty_tag_prf", 32'(tag_PRF), 32'd0);
        tick();

        drive(1'b1, 1'b1, 3'd2, 3'd0, 3'd0);
        settle();
        chk("t3_recycle_ready_out", 32'(ready_out), 32'd1);
        chk("t3_recycle_tag_prf", 32'(tag_PRF), 32'd4);
        chk("t3_recycle_tag_old", 32'(tag_old_PRF), 32'd9);
        chk("t3_recycle_tag_rob", 32'(tag_ROB), 32'd8);
        tick();

        // Empty list does not block an instruction with no destination
        drive(1'b1, 1'b0, 3'd2, 3'd0, 3'd0);
        settle();
        chk("t3_nodst_ready_out", 32'(ready_out), 32'd1);
        chk("t3_nodst_valid_issue", 32'(valid_issue), 32'd1);
        chk("t3_nodst_tag_rob", 32'(tag_ROB), 32'd9);
        tick();

        // Release tag 5 with no instruction
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        valid_commit = 1'b1;
        tag_free     = 4'd5;
        settle();
        chk("t4_idle_valid_issue", 32'(valid_issue), 32'd0);
        tick();

        // RS full holds everything
        drive(1'b1, 1'b1, 3'd4, 3'd0, 3'd0);
        rs_full = 1'b1;
        settle();
        chk("t4_rsfull_ready_out", 32'(ready_out), 32'd0);
        chk("t4_rsfull_valid_issue", 32'(valid_issue), 32'd0);
        chk("t4_rsfull_tag_rob", 32'(tag_ROB), 32'd0);
        tick();

        // ROB full holds everything
        drive(1'b1, 1'b1, 3'd4, 3'd0, 3'd0);
        rob_full = 1'b1;
        settle();
        chk("t4_robfull_ready_out", 32'(ready_out), 32'd0);
        chk("t4_robfull_valid_issue", 32'(valid_issue), 32'd0);
        tick();

        // Released: issues unchanged
        drive(1'b1, 1'b1, 3'd4, 3'd0, 3'd0);
        settle();
        chk("t4_release_valid_issue", 32'(valid_issue), 32'd1);
        chk("t4_release_tag_prf", 32'(tag_PRF), 32'd5);
        chk("t4_release_tag_old", 32'(tag_old_PRF), 32'd11);
        chk("t4_release_tag_rob", 32'(tag_ROB), 32'd10);
        tick();

        // Flush mid-sequence, then 17 fires with tags recycled by commit
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        stop = 1'b1;
        tick();

        last_tag = 4'd1;
        old_prev = 4'd0;
        for (int i = 0; i < 17; i++) begin
            exp_tag = (i < 8) ? 4'(8 + i) : ((i == 8) ? 4'd1 : 4'(i - 1));
            exp_old = last_tag;
            drive(1'b1, 1'b1, 3'd1, 3'd0, 3'd0);
            valid_commit = (i > 0);
            tag_free     = old_prev;
            settle();
            chk("t5_tag_rob", 32'(tag_ROB), 32'(i % 16));
            chk("t5_tag_prf", 32'(exp_tag), 32'(tag_PRF));
            chk("t5_tag_old", 32'(tag_old_PRF), 32'(exp_old));
            tick();
            old_prev = exp_old;
            last_tag = exp_tag;
        end

        // Register 0 as destination and source; RAT[1]=15 is not ready
        drive(1'b1, 1'b1, 3'd0, 3'd0, 3'd1);
        settle();
        chk("t6_valid_issue", 32'(valid_issue), 32'd1);
        chk("t6_tag_rob", 32'(tag_ROB), 32'd1);
        chk("t6_tag_ra", 32'(tag_Ra), 32'd0);
        chk("t6_valid_ra", 32'(valid_Ra), 32'd1);
        chk("t6_tag_rb", 32'(tag_Rb), 32'd15);
        chk("t6_valid_rb", 32'(valid_Rb), 32'd0);
        chk("t6_tag_old", 32'(tag_old_PRF), 32'd0);
`ifdef RENAME_ZERO_REG_EN
        chk("t6_zero_tag_prf", 32'(tag_PRF), 32'd0);
`else
        chk("t6_r0_tag_prf", 32'(tag_PRF), 32'd1);
`endif
        tick();

        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
